vga_sync_rx: RTL and testbench
==============================

# vga_sync_rx

Receive-side counterpart of the VGA text/menu output path. The block samples the hsync/vsync/R/G/B pins as produced by the VGA timing generator and recovers pixel coordinates from the sync pulses alone. It checks line and frame lengths against 640x480 timing, reports lock and timing errors, and counts lit active pixels per frame. It is used as an on-chip loopback monitor and as the bench checker for the menu renderer.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, hsync pulse width in pixels
- H_BP, 48, horizontal back porch
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, active lines
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_TOTAL, 525, lines per frame
- SYNC_ACTIVE_LOW, 1, sync polarity (1: pulse is low)
- LOCK_FRAMES, 2, consecutive good frames needed for lock

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; one pixel per clk cycle with pix_en=1
- hsync, vsync, R, G, B  in  1 each  monitored VGA pins
- x, y  out  10 each  recovered coordinate, valid only when valid=1
- valid  out  1  current pixel is in the active area and locked=1
- rgb  out  3  {R,G,B} aligned with x/y
- frame_start  out  1  one-clk pulse on each vsync assertion edge
- locked  out  1  timing locked
- h_err, v_err  out  1 each  one-clk pulse on a bad line or frame length
- frame_lit  out  20  lit active-pixel count of the previous complete frame

## Operation
- All registers advance only on clk edges with pix_en=1. Exception: pulse outputs clear on the next clk regardless of pix_en.
- Stage 1 registers the pins. Sync levels are normalised to "asserted" using SYNC_ACTIVE_LOW.
- Stage 2 computes the hsync and vsync assertion edges: asserted now and not asserted in the previous sample.
- hcount (10 bit):
  - Set to 0 on an hsync edge, otherwise +1.
  - Saturates at 1023 when no edge arrives.
- vcount (10 bit):
  - On each hsync edge, set to 0 if a vsync edge occurred since the previous hsync edge (pending flag, or a vsync edge in the same sample).
  - Otherwise +1 on each hsync edge; saturates at 1023.
- Active window:
  - hcount in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcount in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - x = hcount-(H_SYNC+H_BP); y = vcount-(V_SYNC+V_BP).
- Line check: on an hsync edge with state≠SEARCH, if the previous hcount+1 ≠ H_TOTAL, pulse h_err.
- Frame check: on a vsync edge with state≠SEARCH, if the line count since the previous vsync edge ≠ V_TOTAL, pulse v_err.
- Lit counter:
  - +1 per in-window sample with R|G|B=1; 20-bit, saturating.
  - On a vsync edge it is copied to frame_lit and cleared.
  - The copy happens only if state≠SEARCH; otherwise it is only cleared.
- State machine (lock_cnt counts good frames):
  - SEARCH → ACQUIRE on the first vsync edge; lock_cnt=0.
  - ACQUIRE, vsync edge, frame good: lock_cnt+1. Enter LOCKED when lock_cnt reaches LOCK_FRAMES.
  - ACQUIRE, any h_err/v_err: stay in ACQUIRE, lock_cnt=0.
  - LOCKED, any h_err/v_err: go to ACQUIRE, lock_cnt=0, locked drops on the same edge.
  - A frame is "good" if no h_err and no v_err occurred since the previous vsync edge.
- If the same sample produces both h_err and a vsync edge, the error takes priority: the frame is not counted as good.

## Timing
- Reset values: x=0, y=0, valid=0, rgb=0, frame_start=0, locked=0, h_err=0, v_err=0, frame_lit=0; state=SEARCH; all counters 0.
- Latency:
  - Pin sample to x/y/valid/rgb: 2 pix_en cycles.
  - frame_start, h_err, v_err: same edge as stage 2 detects the event.
- Pulses last exactly one clk even if pix_en stays low afterwards.
- pix_en=0 freezes every counter, output and state; nothing is lost.
- Reset mid-frame returns to SEARCH. The first partial frame after reset never counts toward lock.
- hcount wraps only through an hsync edge. Saturation at 1023 makes a missing hsync produce h_err on the next edge.

## Test plan
- Reset, then an ideal 640x480 stream with pix_en=1 every cycle → locked=0 through the 2nd vsync edge, locked=1 at the 3rd vsync edge; no h_err/v_err.
- Locked stream with a lit 8x4 block at x=500..507, y=400..403 → at the next vsync edge frame_lit=32; valid=1 with x=500, y=400 on the first lit rgb.
- Inject one 799-pixel line while locked → single h_err pulse, locked falls on the same edge, relock after 2 further good frames.
- Frame of 524 lines → v_err at its closing vsync edge, state ACQUIRE, frame_lit not updated.
- pix_en toggling 1-of-4 (100 MHz clk, 25 MHz pixels) with the same stream → identical x/y/locked sequence as the first scenario, stretched 4x.
- Assert rst mid-frame while locked → all outputs at reset values on the next clk; lock reacquired 3 vsync edges after release.

Source files
------------

// File: rtl/vga_sync_rx_if.sv
// Monitored VGA pins plus the recovered-timing results of vga_sync_rx.
// master drives the pins (generator / bench side), slave is the monitor.
interface vga_sync_rx_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic        R;
  logic        G;
  logic        B;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        valid;
  logic [2:0]  rgb;
  logic        frame_start;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic [19:0] frame_lit;

  modport master (
    output pix_en, hsync, vsync, R, G, B,
    input  x, y, valid, rgb, frame_start, locked, h_err, v_err, frame_lit
  );

  modport slave (
    input  pix_en, hsync, vsync, R, G, B,
    output x, y, valid, rgb, frame_start, locked, h_err, v_err, frame_lit
  );
endinterface

// File: rtl/vga_sync_rx.sv
// Recovers pixel coordinates from sampled VGA sync pins, checks line/frame
// lengths, tracks lock and counts lit active pixels per frame.
module vga_sync_rx #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned V_TOTAL         = 525,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = 2
) (
  input  logic         clk,
  input  logic         rst,
  vga_sync_rx_if.slave vga
);

  localparam int unsigned CW  = 10;
  localparam int unsigned LW  = 20;
  localparam int unsigned EW  = CW + 1;
  localparam int unsigned HO  = H_SYNC + H_BP;
  localparam int unsigned VO  = V_SYNC + V_BP;
  localparam int unsigned LCW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;

  logic            hs1_q, vs1_q, hs2_q, vs2_q;
  logic [2:0]      rgb1_q;
  logic [CW-1:0]   hcount_q, hcount_d;
  logic [CW-1:0]   vcount_q, vcount_d;
  logic [CW-1:0]   line_cnt_q, line_cnt_d;
  logic            vpend_q, vpend_d;
  logic [LW-1:0]   lit_q, lit_d;
  logic            bad_q, bad_d;

  logic [CW-1:0]   x_q, y_q;
  logic            valid_q, locked_q;
  logic [2:0]      rgb_q;
  logic            fs_q, herr_q, verr_q;
  logic [LW-1:0]   frame_lit_q, frame_lit_d;

  logic            hs_edge, vs_edge, searching, h_err_c, v_err_c, in_win;

  // Datapath: edges, counters, checks and lit accumulation for the stage-1 sample
  always_comb begin
    hs_edge   = hs1_q & ~hs2_q;
    vs_edge   = vs1_q & ~vs2_q;
    searching = (state_q == SEARCH);

    h_err_c = hs_edge && !searching &&
              ((EW'(hcount_q) + EW'(1)) != EW'(H_TOTAL));
    v_err_c = vs_edge && !searching &&
              ((EW'(line_cnt_q) + EW'(hs_edge)) != EW'(V_TOTAL));

    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    vpend_d    = vpend_q;
    line_cnt_d = line_cnt_q;

    if (hs_edge) begin
      hcount_d = '0;
    end else if (hcount_q != '1) begin
      hcount_d = hcount_q + CW'(1);
    end

    // vcount restarts on the first hsync edge at or after a vsync edge
    if (hs_edge) begin
      vpend_d = 1'b0;
      if (vpend_q || vs_edge) begin
        vcount_d = '0;
      end else if (vcount_q != '1) begin
        vcount_d = vcount_q + CW'(1);
      end
    end else if (vs_edge) begin
      vpend_d = 1'b1;
    end

    if (vs_edge) begin
      line_cnt_d = '0;
    end else if (hs_edge && (line_cnt_q != '1)) begin
      line_cnt_d = line_cnt_q + CW'(1);
    end

    in_win = (hcount_d >= CW'(HO)) && (hcount_d < CW'(HO + H_ACTIVE)) &&
             (vcount_d >= CW'(VO)) && (vcount_d < CW'(VO + V_ACTIVE));

    lit_d       = lit_q;
    frame_lit_d = frame_lit_q;
    if (vs_edge) begin
      lit_d = '0;
      // A wrong-length frame leaves the previously published count in place
      if (!searching && !v_err_c) begin
        frame_lit_d = lit_q;
      end
    end else if (in_win && (|rgb1_q) && (lit_q != '1)) begin
      lit_d = lit_q + LW'(1);
    end

    bad_d = vs_edge ? 1'b0 : (bad_q | h_err_c | v_err_c);
  end

  // Lock state machine: next state
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d    = ACQUIRE;
          lock_cnt_d = '0;
        end
      end
      ACQUIRE: begin
        if (h_err_c || v_err_c) begin
          lock_cnt_d = '0;
        end else if (vs_edge && !bad_q) begin
          if ((lock_cnt_q + LCW'(1)) >= LCW'(LOCK_FRAMES)) begin
            state_d    = LOCKED;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end
        end
      end
      LOCKED: begin
        if (h_err_c || v_err_c) begin
          state_d    = ACQUIRE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = SEARCH;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Lock state machine: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      lock_cnt_q <= '0;
    end else if (vga.pix_en) begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Pipeline, counters and level outputs; frozen while pix_en is low
  always_ff @(posedge clk) begin
    if (rst) begin
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      rgb1_q      <= '0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      hcount_q    <= '0;
      vcount_q    <= '0;
      line_cnt_q  <= '0;
      vpend_q     <= 1'b0;
      lit_q       <= '0;
      bad_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      rgb_q       <= '0;
      frame_lit_q <= '0;
    end else if (vga.pix_en) begin
      hs1_q       <= vga.hsync ^ SYNC_ACTIVE_LOW;
      vs1_q       <= vga.vsync ^ SYNC_ACTIVE_LOW;
      rgb1_q      <= {vga.R, vga.G, vga.B};
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      line_cnt_q  <= line_cnt_d;
      vpend_q     <= vpend_d;
      lit_q       <= lit_d;
      bad_q       <= bad_d;
      x_q         <= hcount_d - CW'(HO);
      y_q         <= vcount_d - CW'(VO);
      valid_q     <= in_win && (state_d == LOCKED);
      locked_q    <= (state_d == LOCKED);
      rgb_q       <= rgb1_q;
      frame_lit_q <= frame_lit_d;
    end
  end

  // Event pulses last exactly one clk, independent of pix_en
  always_ff @(posedge clk) begin
    if (rst || !vga.pix_en) begin
      fs_q   <= 1'b0;
      herr_q <= 1'b0;
      verr_q <= 1'b0;
    end else begin
      fs_q   <= vs_edge;
      herr_q <= h_err_c;
      verr_q <= v_err_c;
    end
  end

  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.valid       = valid_q;
  assign vga.rgb         = rgb_q;
  assign vga.frame_start = fs_q;
  assign vga.locked      = locked_q;
  assign vga.h_err       = herr_q;
  assign vga.v_err       = verr_q;
  assign vga.frame_lit   = frame_lit_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a scaled-down raster: frame table with expected
// lock/error/lit results, plus a per-sample behavioural model of the monitor.
module tb_vga_sync_rx;

  localparam int HA = 16, HS = 4, HB = 3, HT = 28;
  localparam int VA = 10, VS = 2, VB = 3, VT = 18;
  localparam int LF = 2;
  localparam int HO = HS + HB;
  localparam int VO = VS + VB;
  localparam bit SAL = 1'b1;
  localparam int LIT_MAX = (1 << 20) - 1;

  logic clk;
  logic rst;

  vga_sync_rx_if bus ();

  vga_sync_rx #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_ACTIVE_LOW(SAL), .LOCK_FRAMES(LF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vga (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        valid;
    logic [2:0]  rgb;
    logic        fs;
    logic        locked;
    logic        herr;
    logic        verr;
    logic [19:0] lit;
  } obs_t;

  typedef struct {
    int lines;
    int bad_line;
    int bad_len;
    int mode;       // 0 dark, 1 8x4 block, 2 random rgb with random pix_en gaps
    bit exp_locked;
    int exp_herr;
    int exp_verr;
    int exp_lit;    // -1: left to the per-sample model
  } frame_vec_t;

  typedef struct {
    bit locked;
    int herr;
    int verr;
    int lit;
  } snap_t;

  int n_tests;
  int n_fail;

  snap_t snaps[$];
  int    herr_acc, verr_acc;
  bit    first_lit_seen;
  logic [22:0] first_lit;

  // Behavioural model state (plain integers, frame-level bookkeeping)
  bit m_prev_hs, m_prev_vs, m_vpend, m_seen, m_locked, m_frame_bad;
  int m_hpos, m_vpos, m_lines, m_lit, m_frame_lit, m_good_run;

  bit         p_hs, p_vs;
  logic [2:0] p_rgb;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sat_inc(int v, int lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  function automatic void model_reset();
    m_prev_hs = 0; m_prev_vs = 0; m_vpend = 0; m_seen = 0; m_locked = 0;
    m_frame_bad = 0; m_hpos = 0; m_vpos = 0; m_lines = 0; m_lit = 0;
    m_frame_lit = 0; m_good_run = 0;
    p_hs = 0; p_vs = 0; p_rgb = 3'b000;
  endfunction

  // Expected outputs once the monitor has absorbed sample (hs, vs, c)
  function automatic obs_t model_step(bit hs, bit vs, logic [2:0] c);
    obs_t e;
    bit hedge, vedge, herr, verr, err, win;
    hedge = hs && !m_prev_hs;
    vedge = vs && !m_prev_vs;
    m_prev_hs = hs;
    m_prev_vs = vs;
    herr = hedge && m_seen && (m_hpos + 1 != HT);
    verr = vedge && m_seen && (m_lines + int'(hedge) != VT);
    err  = herr || verr;

    m_hpos = hedge ? 0 : sat_inc(m_hpos, 1023);
    if (hedge) begin
      m_vpos  = (m_vpend || vedge) ? 0 : sat_inc(m_vpos, 1023);
      m_vpend = 0;
    end else if (vedge) begin
      m_vpend = 1;
    end
    if (vedge) m_lines = 0;
    else if (hedge) m_lines = sat_inc(m_lines, 1023);

    win = (m_hpos >= HO) && (m_hpos < HO + HA) && (m_vpos >= VO) && (m_vpos < VO + VA);
    if (vedge) begin
      if (m_seen && !verr) m_frame_lit = m_lit;
      m_lit = 0;
    end else if (win && c != 3'b000) begin
      m_lit = sat_inc(m_lit, LIT_MAX);
    end

    if (!m_seen) begin
      if (vedge) begin
        m_seen = 1;
        m_good_run = 0;
      end
    end else begin
      if (err) begin
        m_locked = 0;
        m_good_run = 0;
      end
      if (vedge && !m_frame_bad && !err && !m_locked) begin
        m_good_run++;
        if (m_good_run >= LF) begin
          m_locked = 1;
          m_good_run = 0;
        end
      end
    end
    m_frame_bad = vedge ? 1'b0 : (m_frame_bad || err);

    e.x      = 10'(m_hpos - HO);
    e.y      = 10'(m_vpos - VO);
    e.valid  = win && m_locked;
    e.rgb    = c;
    e.fs     = vedge;
    e.locked = m_locked;
    e.herr   = herr;
    e.verr   = verr;
    e.lit    = 20'(m_frame_lit);
    return e;
  endfunction

  function automatic obs_t sample_out();
    obs_t a;
    a.x = bus.x; a.y = bus.y; a.valid = bus.valid; a.rgb = bus.rgb;
    a.fs = bus.frame_start; a.locked = bus.locked; a.herr = bus.h_err;
    a.verr = bus.v_err; a.lit = bus.frame_lit;
    return a;
  endfunction

  function automatic void compare_out(obs_t e, string name);
    obs_t  a;
    snap_t s;
    a = sample_out();
    herr_acc += int'(a.herr);
    verr_acc += int'(a.verr);
    if (a.fs) begin
      s.locked = a.locked; s.herr = herr_acc; s.verr = verr_acc; s.lit = int'(a.lit);
      snaps.push_back(s);
      herr_acc = 0;
      verr_acc = 0;
    end
    if (!first_lit_seen && a.valid && a.rgb != 3'b000) begin
      first_lit_seen = 1;
      first_lit = {a.x, a.y, a.rgb};
    end
    if (!e.valid) begin
      a.x = '0; a.y = '0; e.x = '0; e.y = '0;
    end
    check(name, 64'(a), 64'(e));
  endfunction

  task automatic pix(input bit hs, input bit vs, input logic [2:0] c, input int gap);
    obs_t e;
    bus.hsync  = hs ^ SAL;
    bus.vsync  = vs ^ SAL;
    bus.R      = c[2];
    bus.G      = c[1];
    bus.B      = c[0];
    bus.pix_en = 1'b1;
    @(posedge clk);
    #1;
    e = model_step(p_hs, p_vs, p_rgb);
    p_hs = hs; p_vs = vs; p_rgb = c;
    compare_out(e, "stream");
    e.fs = 1'b0; e.herr = 1'b0; e.verr = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.pix_en = 1'b0;
      @(posedge clk);
      #1;
      compare_out(e, "hold");
    end
  endtask

  // Emit raster positions (l0,p0) up to but excluding (l1,p1)
  task automatic gen_span(input int l0, input int p0, input int l1, input int p1,
                          input int bad_line, input int bad_len, input int mode,
                          input int gap_mode);
    int l, p, len, ax, ay, gap;
    logic [2:0] c;
    l = l0;
    p = p0;
    while (l < l1 || (l == l1 && p < p1)) begin
      len = (l == bad_line) ? bad_len : HT;
      ax  = p - HO;
      ay  = l - VO;
      c   = 3'b000;
      if (mode == 1 && ax >= 4 && ax <= 11 && ay >= 3 && ay <= 6) c = 3'b110;
      if (mode == 2 && $urandom_range(0, 2) == 0) c = 3'($urandom_range(1, 7));
      gap = (gap_mode == 1) ? 3 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      pix(p < HS, l < VS, c, gap);
      p++;
      if (p >= len) begin
        p = 0;
        l++;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus.pix_en = 1'b1;
    bus.hsync = ~SAL; bus.vsync = ~SAL;
    bus.R = 1'b0; bus.G = 1'b0; bus.B = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset_outputs", 64'(sample_out()), 64'd0);
    end
    rst = 1'b0;
    model_reset();
    snaps.delete();
    herr_acc = 0;
    verr_acc = 0;
  endtask

  task automatic check_locks(input string name, input int n, input bit exp[4]);
    check({name, "_frame_starts"}, 64'(snaps.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < snaps.size()) begin
        check($sformatf("%s_locked_%0d", name, i), 64'(snaps[i].locked), 64'(exp[i]));
        check($sformatf("%s_errs_%0d", name, i), 64'(snaps[i].herr + snaps[i].verr), 64'd0);
      end
    end
  endtask

  frame_vec_t vec[10];
  bit         exp_lock[4];

  initial begin
    n_tests = 0;
    n_fail = 0;
    first_lit_seen = 0;
    first_lit = '0;
    rst = 1'b1;
    bus.pix_en = 1'b0;
    model_reset();

    vec[0] = '{18, -1,  0, 0, 1'b0, 0, 0,  0};
    vec[1] = '{18, -1,  0, 0, 1'b1, 0, 0,  0};
    vec[2] = '{18, -1,  0, 1, 1'b1, 0, 0, 32};
    vec[3] = '{18, -1,  0, 2, 1'b1, 0, 0, -1};
    vec[4] = '{18,  7, 27, 0, 1'b0, 1, 0,  0};
    vec[5] = '{18, -1,  0, 0, 1'b0, 0, 0,  0};
    vec[6] = '{18, -1,  0, 0, 1'b1, 0, 0,  0};
    vec[7] = '{17, -1,  0, 1, 1'b0, 0, 1,  0};
    vec[8] = '{18, -1,  0, 0, 1'b0, 0, 0,  0};
    vec[9] = '{18, -1,  0, 1, 1'b1, 0, 0, 32};

    do_reset(3);

    // Frame table: record i is judged at the vsync edge that closes frame i
    foreach (vec[i]) begin
      gen_span(0, 0, vec[i].lines, 0, vec[i].bad_line, vec[i].bad_len,
               vec[i].mode, (vec[i].mode == 2) ? 2 : 0);
    end
    gen_span(0, 0, 1, 0, -1, 0, 0, 0);
    check("table_frame_starts", 64'(snaps.size()), 64'(11));
    foreach (vec[i]) begin
      if (i + 1 < snaps.size()) begin
        check($sformatf("frame%0d_locked", i), 64'(snaps[i+1].locked), 64'(vec[i].exp_locked));
        check($sformatf("frame%0d_h_err", i), 64'(snaps[i+1].herr), 64'(vec[i].exp_herr));
        check($sformatf("frame%0d_v_err", i), 64'(snaps[i+1].verr), 64'(vec[i].exp_verr));
        if (vec[i].exp_lit >= 0)
          check($sformatf("frame%0d_lit", i), 64'(snaps[i+1].lit), 64'(vec[i].exp_lit));
      end
    end
    check("first_lit_pixel", 64'({first_lit_seen, first_lit}),
          64'({1'b1, 10'd4, 10'd3, 3'b110}));

    // Reset in the middle of an active line while locked, then relock
    gen_span(1, 0, 8, 12, -1, 0, 0, 0);
    do_reset(1);
    gen_span(8, 12, VT, 0, -1, 0, 0, 0);
    gen_span(0, 0, VT, 0, -1, 0, 0, 0);
    gen_span(0, 0, VT, 0, -1, 0, 0, 0);
    gen_span(0, 0, 1, 0, -1, 0, 0, 0);
    exp_lock = '{1'b0, 1'b0, 1'b1, 1'b0};
    check_locks("midreset", 3, exp_lock);

    // One pixel every fourth clk
    do_reset(2);
    for (int f = 0; f < 3; f++) gen_span(0, 0, VT, 0, -1, 0, 0, 1);
    gen_span(0, 0, 1, 0, -1, 0, 0, 1);
    exp_lock = '{1'b0, 1'b0, 1'b1, 1'b1};
    check_locks("slow_pix", 4, exp_lock);

    bus.pix_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
